// File: rtl/mem_map_pkg.sv
// Memory-map constants, access-size encodings and response source select
// shared by the data-side memory port arbiter and its lane generator.
package mem_map_pkg;

    localparam logic [3:0] SPACE_DMEM  = 4'b0001;
    localparam logic [3:0] SPACE_IMEM  = 4'b0010;
    localparam logic [3:0] SPACE_DIMEM = 4'b0011;
    localparam logic [3:0] SPACE_BIOS  = 4'b0100;
    localparam logic [3:0] SPACE_IO    = 4'b1000;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DMEM = 2'd1,
        SRC_BIOS = 2'd2,
        SRC_IO   = 2'd3
    } src_sel_e;

    typedef struct packed {
        logic     valid;
        logic     id;
        logic     err;
        logic     is_load;
        src_sel_e src_sel;
    } rsp_reg_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if;

    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [1:0]  cpu_size;

    logic        dma_valid;
    logic        dma_ready;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_we;
    logic [1:0]  dma_size;

    logic        imem_wr_en;

    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic [13:0] mem_addr;
    logic [11:0] bios_addr;
    logic [3:0]  dmem_we;
    logic [3:0]  imem_we;
    logic [3:0]  io_we;
    logic [31:0] mem_wdata;
    logic        io_re;

    logic [31:0] dmem_dout;
    logic [31:0] bios_dout;
    logic [31:0] io_dout;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_we, cpu_size,
        input  dma_valid, dma_addr, dma_wdata, dma_we, dma_size,
        input  imem_wr_en,
        input  dmem_dout, bios_dout, io_dout,
        output cpu_ready, dma_ready,
        output rsp_valid, rsp_id, rsp_err, rsp_rdata,
        output mem_addr, bios_addr, dmem_we, imem_we, io_we, mem_wdata, io_re
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_we, cpu_size,
        output dma_valid, dma_addr, dma_wdata, dma_we, dma_size,
        output imem_wr_en,
        output dmem_dout, bios_dout, io_dout,
        input  cpu_ready, dma_ready,
        input  rsp_valid, rsp_id, rsp_err, rsp_rdata,
        input  mem_addr, bios_addr, dmem_we, imem_we, io_we, mem_wdata, io_re
    );

endinterface

// File: rtl/byte_lane_gen.sv
// Turns an access size and low address bits into byte-lane write enables,
// lane-aligned store data and an alignment error flag.
module byte_lane_gen
    import mem_map_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  we_mask,
    output logic [31:0] wdata_shifted,
    output logic        misaligned
);

    // Misaligned and illegal sizes leave the mask empty so nothing is written.
    always_comb begin
        we_mask       = 4'b0000;
        wdata_shifted = 32'd0;
        misaligned    = 1'b0;
        case (size)
            SZ_B: begin
                we_mask       = 4'b0001 << addr_lo;
                wdata_shifted = {24'd0, wdata[7:0]} << {addr_lo, 3'b000};
            end
            SZ_H: begin
                if (addr_lo[0]) begin
                    misaligned = 1'b1;
                end else if (addr_lo[1]) begin
                    we_mask       = 4'b1100;
                    wdata_shifted = {wdata[15:0], 16'd0};
                end else begin
                    we_mask       = 4'b0011;
                    wdata_shifted = {16'd0, wdata[15:0]};
                end
            end
            SZ_W: begin
                if (addr_lo != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    we_mask       = 4'b1111;
                    wdata_shifted = wdata;
                end
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-side memory port between the CPU memory stage and the DMA
// engine: CPU-priority arbitration with a starvation guard, decode, and a
// one-cycle response stage.
module mem_port_arbiter
    import mem_map_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_dma;
    logic             cpu_grant;
    logic             dma_grant;
    logic             any_grant;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic [3:0]  space;

    logic [3:0]  lane_mask;
    logic        misaligned;

    logic        dmem_hit;
    logic        imem_hit;
    logic        io_hit;
    logic        decode_err;
    src_sel_e    load_src;
    logic        txn_err;
    logic        txn_ok;

    rsp_reg_t    rsp_q;
    logic [31:0] rdata_mux;
    logic        unused_addr_bits;

    // Nothing is accepted while in reset, so a request is never lost to it.
    assign force_dma     = (starve_cnt == LIMIT);
    assign bus.cpu_ready = !rst && (!force_dma || !bus.dma_valid);
    assign bus.dma_ready = !rst && (!bus.cpu_valid || force_dma);
    assign cpu_grant     = bus.cpu_valid && bus.cpu_ready;
    assign dma_grant     = bus.dma_valid && bus.dma_ready;
    assign any_grant     = cpu_grant || dma_grant;

    assign req_addr  = dma_grant ? bus.dma_addr  : bus.cpu_addr;
    assign req_wdata = dma_grant ? bus.dma_wdata : bus.cpu_wdata;
    assign req_we    = dma_grant ? bus.dma_we    : bus.cpu_we;
    assign req_size  = dma_grant ? bus.dma_size  : bus.cpu_size;
    assign space     = req_addr[31:28];

    assign bus.mem_addr  = req_addr[15:2];
    assign bus.bios_addr = req_addr[13:2];
    assign unused_addr_bits = ^req_addr[27:16];

    byte_lane_gen u_lanes (
        .size          (req_size),
        .addr_lo       (req_addr[1:0]),
        .wdata         (req_wdata),
        .we_mask       (lane_mask),
        .wdata_shifted (bus.mem_wdata),
        .misaligned    (misaligned)
    );

    // The shared DMem/IMem window stores to DMem always and mirrors into IMem
    // only while the CPU runs from BIOS; IMem is never a load source.
    always_comb begin
        dmem_hit   = 1'b0;
        imem_hit   = 1'b0;
        io_hit     = 1'b0;
        decode_err = 1'b0;
        load_src   = SRC_NONE;
        if (req_we) begin
            case (space)
                SPACE_DMEM:  dmem_hit = 1'b1;
                SPACE_IMEM: begin
                    imem_hit   = bus.imem_wr_en;
                    decode_err = !bus.imem_wr_en;
                end
                SPACE_DIMEM: begin
                    dmem_hit = 1'b1;
                    imem_hit = bus.imem_wr_en;
                end
                SPACE_IO:    io_hit = 1'b1;
                default:     decode_err = 1'b1;
            endcase
        end else begin
            case (space)
                SPACE_DMEM, SPACE_DIMEM: load_src = SRC_DMEM;
                SPACE_BIOS:              load_src = SRC_BIOS;
                SPACE_IO:                load_src = SRC_IO;
                default:                 decode_err = 1'b1;
            endcase
        end
    end

    assign txn_err = decode_err || misaligned;
    assign txn_ok  = any_grant && !txn_err;

    assign bus.dmem_we = (txn_ok && req_we && dmem_hit) ? lane_mask : 4'b0000;
    assign bus.imem_we = (txn_ok && req_we && imem_hit) ? lane_mask : 4'b0000;
    assign bus.io_we   = (txn_ok && req_we && io_hit)   ? lane_mask : 4'b0000;
    assign bus.io_re   = txn_ok && !req_we && (load_src == SRC_IO);

    // Counts CPU wins over a waiting DMA; any DMA win or DMA idle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (dma_grant || !bus.dma_valid) begin
            starve_cnt <= '0;
        end else if (cpu_grant && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
        end else begin
            rsp_q.valid   <= any_grant;
            rsp_q.id      <= dma_grant;
            rsp_q.err     <= any_grant && txn_err;
            rsp_q.is_load <= any_grant && !req_we;
            rsp_q.src_sel <= (txn_ok && !req_we) ? load_src : SRC_NONE;
        end
    end

    // The response visible during reset is suppressed so a dropped
    // transaction never shows up as valid.
    always_comb begin
        rdata_mux = 32'd0;
        if (rsp_q.valid && rsp_q.is_load && !rsp_q.err && !rst) begin
            case (rsp_q.src_sel)
                SRC_DMEM: rdata_mux = bus.dmem_dout;
                SRC_BIOS: rdata_mux = bus.bios_dout;
                SRC_IO:   rdata_mux = bus.io_dout;
                default:  rdata_mux = 32'd0;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_q.valid && !rst;
    assign bus.rsp_id    = rsp_q.id && !rst;
    assign bus.rsp_err   = rsp_q.err && !rst;
    assign bus.rsp_rdata = rdata_mux;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-feature tasks check the
// combinational port outputs, a scoreboard checks every response.
module tb_mem_port_arbiter;
    import mem_map_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    typedef struct {
        bit         id;
        bit         err;
        logic [1:0] src;
    } exp_rsp_t;

    exp_rsp_t sb[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference decode: response the arbiter owes for one accepted request.
    function automatic exp_rsp_t model(input bit id, input logic [31:0] a, input logic we,
                                       input logic [1:0] sz, input logic imem_en);
        exp_rsp_t   e;
        logic [3:0] sp;
        bit         mis;
        bit         derr;
        sp    = a[31:28];
        e.id  = id;
        e.src = 2'd0;
        mis   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        if (we) begin
            derr = !(sp == 4'h1 || sp == 4'h3 || sp == 4'h8 || (sp == 4'h2 && imem_en));
        end else begin
            derr = !(sp == 4'h1 || sp == 4'h3 || sp == 4'h4 || sp == 4'h8);
            if (!derr && !mis) e.src = (sp == 4'h4) ? 2'd2 : (sp == 4'h8) ? 2'd3 : 2'd1;
        end
        e.err = mis || derr;
        return e;
    endfunction

    task automatic drive_cpu(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic we, input logic [1:0] sz);
        bus.cpu_valid = v;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = we;
        bus.cpu_size  = sz;
    endtask

    task automatic drive_dma(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic we, input logic [1:0] sz);
        bus.dma_valid = v;
        bus.dma_addr  = a;
        bus.dma_wdata = d;
        bus.dma_we    = we;
        bus.dma_size  = sz;
    endtask

    // Called at the negedge: records this cycle's handshake, crosses the
    // clock edge and then checks the response against the scoreboard.
    task automatic advance_cycle(input bit rst_next);
        bit          cpu_hs;
        bit          dma_hs;
        bit          exp_v;
        exp_rsp_t    e;
        logic [31:0] exp_rd;
        cpu_hs = bus.cpu_valid && bus.cpu_ready;
        dma_hs = bus.dma_valid && bus.dma_ready;
        if (rst) begin
            sb.delete();
        end else begin
            if (cpu_hs || dma_hs) begin
                n_cmp++;
                if (cpu_hs && dma_hs) begin
                    n_fail++;
                    $display("[TB] FAIL single_grant: got both accepted, want exactly one");
                end
            end
            if (cpu_hs)
                sb.push_back(model(1'b0, bus.cpu_addr, bus.cpu_we, bus.cpu_size, bus.imem_wr_en));
            else if (dma_hs)
                sb.push_back(model(1'b1, bus.dma_addr, bus.dma_we, bus.dma_size, bus.imem_wr_en));
        end
        @(posedge clk);
        #1;
        if (rst_next) rst = 1'b1;
        #1;
        exp_v = (sb.size() > 0) && !rst;
        n_cmp++;
        if (bus.rsp_valid !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL rsp_valid: got %b want %b", bus.rsp_valid, exp_v);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (exp_v) begin
                case (e.src)
                    2'd1:    exp_rd = bus.dmem_dout;
                    2'd2:    exp_rd = bus.bios_dout;
                    2'd3:    exp_rd = bus.io_dout;
                    default: exp_rd = 32'd0;
                endcase
                n_cmp++;
                if (bus.rsp_id !== e.id) begin
                    n_fail++;
                    $display("[TB] FAIL rsp_id: got %b want %b", bus.rsp_id, e.id);
                end
                n_cmp++;
                if (bus.rsp_err !== e.err) begin
                    n_fail++;
                    $display("[TB] FAIL rsp_err: got %b want %b", bus.rsp_err, e.err);
                end
                n_cmp++;
                if (bus.rsp_rdata !== exp_rd) begin
                    n_fail++;
                    $display("[TB] FAIL rsp_rdata: got %h want %h", bus.rsp_rdata, exp_rd);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cpu(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 1'b1, SZ_W);
        @(negedge clk);
        n_cmp++;
        if (bus.dmem_we !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_dmem_we: got %b want 0000", bus.dmem_we);
        end
        advance_cycle(1'b0);
        @(negedge clk);
        n_cmp++;
        if ({bus.rsp_id, bus.rsp_err} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp_flags: got %b want 00", {bus.rsp_id, bus.rsp_err});
        end
        advance_cycle(1'b0);
        drive_cpu(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp_rdata: got %h want 00000000", bus.rsp_rdata);
        end
        advance_cycle(1'b0);
    endtask

    task automatic test_store_lanes();
        drive_cpu(1'b1, 32'h1000_0003, 32'h0000_00A5, 1'b1, SZ_B);
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_we, bus.imem_we, bus.io_we} !== 12'b1000_0000_0000) begin
            n_fail++;
            $display("[TB] FAIL byte_we: got %b/%b/%b want 1000/0000/0000", bus.dmem_we, bus.imem_we, bus.io_we);
        end
        n_cmp++;
        if (bus.mem_wdata !== 32'hA500_0000) begin
            n_fail++;
            $display("[TB] FAIL byte_wdata: got %h want a5000000", bus.mem_wdata);
        end
        n_cmp++;
        if (bus.mem_addr !== 14'h0000) begin
            n_fail++;
            $display("[TB] FAIL byte_addr: got %h want 0000", bus.mem_addr);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b1, 32'h1000_0105, 32'hFFFF_FF3C, 1'b1, SZ_B);
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_we, bus.mem_wdata, bus.mem_addr} !== {4'b0010, 32'h0000_3C00, 14'h0041}) begin
            n_fail++;
            $display("[TB] FAIL byte1: got %b %h %h want 0010 00003c00 0041", bus.dmem_we, bus.mem_wdata, bus.mem_addr);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b1, 32'h1000_0002, 32'h0000_1234, 1'b1, SZ_H);
        @(negedge clk);
        n_cmp++;
        if (bus.dmem_we !== 4'b1100) begin
            n_fail++;
            $display("[TB] FAIL half_we: got %b want 1100", bus.dmem_we);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        advance_cycle(1'b0);
    endtask

    task automatic test_dimem();
        bus.imem_wr_en = 1'b0;
        drive_cpu(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 1'b1, SZ_W);
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_we, bus.imem_we, bus.mem_addr} !== {4'b1111, 4'b0000, 14'h0004}) begin
            n_fail++;
            $display("[TB] FAIL dimem_noimem: got %b/%b %h want 1111/0000 0004", bus.dmem_we, bus.imem_we, bus.mem_addr);
        end
        advance_cycle(1'b0);
        bus.imem_wr_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_we, bus.imem_we} !== 8'b1111_1111) begin
            n_fail++;
            $display("[TB] FAIL dimem_imem: got %b/%b want 1111/1111", bus.dmem_we, bus.imem_we);
        end
        advance_cycle(1'b0);
        bus.imem_wr_en = 1'b0;
        drive_cpu(1'b1, 32'h2000_0010, 32'hCAFE_F00D, 1'b1, SZ_W);
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_we, bus.imem_we, bus.io_we} !== 12'd0) begin
            n_fail++;
            $display("[TB] FAIL imem_locked_we: got %b/%b/%b want all 0", bus.dmem_we, bus.imem_we, bus.io_we);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b1, 32'h8000_0000, 32'h0000_0041, 1'b1, SZ_B);
        @(negedge clk);
        n_cmp++;
        if ({bus.io_we, bus.dmem_we} !== 8'b0001_0000) begin
            n_fail++;
            $display("[TB] FAIL io_store_we: got %b/%b want 0001/0000", bus.io_we, bus.dmem_we);
        end
        advance_cycle(1'b0);
    endtask

    task automatic test_loads();
        drive_cpu(1'b1, 32'h4000_0008, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        n_cmp++;
        if ({bus.bios_addr, bus.io_re, bus.dmem_we} !== {12'd2, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("[TB] FAIL bios_load: got addr %0d io_re %b we %b want 2 0 0000", bus.bios_addr, bus.io_re, bus.dmem_we);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b1, 32'h8000_0004, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        n_cmp++;
        if (bus.io_re !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL io_re_on: got %b want 1", bus.io_re);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b0, 32'h8000_0004, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        n_cmp++;
        if (bus.io_re !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL io_re_off: got %b want 0", bus.io_re);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b1, 32'h1000_0020, 32'h0, 1'b0, SZ_H);
        @(negedge clk);
        advance_cycle(1'b0);
        drive_cpu(1'b1, 32'h2000_0000, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        advance_cycle(1'b0);
    endtask

    task automatic test_misaligned();
        drive_cpu(1'b1, 32'h1000_0001, 32'h0000_BEEF, 1'b1, SZ_H);
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_we, bus.imem_we, bus.io_we} !== 12'd0) begin
            n_fail++;
            $display("[TB] FAIL misaligned_we: got %b/%b/%b want all 0", bus.dmem_we, bus.imem_we, bus.io_we);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b1, 32'h8000_0000, 32'h0, 1'b0, 2'b11);
        @(negedge clk);
        n_cmp++;
        if (bus.io_re !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL illegal_size_io_re: got %b want 0", bus.io_re);
        end
        advance_cycle(1'b0);
        drive_cpu(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        advance_cycle(1'b0);
    endtask

    task automatic test_starvation();
        int cnt = 0;
        bit exp_dma;
        drive_cpu(1'b1, 32'h1000_0004, 32'h0, 1'b0, SZ_W);
        drive_dma(1'b1, 32'h1000_0008, 32'h0000_55AA, 1'b1, SZ_W);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_dma = (cnt == 4);
            n_cmp++;
            if ({bus.cpu_ready, bus.dma_ready} !== {!exp_dma, exp_dma}) begin
                n_fail++;
                $display("[TB] FAIL starve_grant[%0d]: got cpu %b dma %b want cpu %b dma %b", i, bus.cpu_ready, bus.dma_ready, !exp_dma, exp_dma);
            end
            advance_cycle(1'b0);
            cnt = exp_dma ? 0 : cnt + 1;
        end
        drive_cpu(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        n_cmp++;
        if (bus.dma_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL dma_alone: got %b want 1", bus.dma_ready);
        end
        advance_cycle(1'b0);
        drive_dma(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        advance_cycle(1'b0);
    endtask

    task automatic test_reset_mid();
        bit exp_dma;
        drive_dma(1'b1, 32'h4000_0000, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        n_cmp++;
        if (bus.dma_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_dma_accept: got %b want 1", bus.dma_ready);
        end
        advance_cycle(1'b1);
        drive_dma(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        drive_cpu(1'b1, 32'h1000_0000, 32'h1111_2222, 1'b1, SZ_W);
        @(negedge clk);
        n_cmp++;
        if ({bus.dmem_we, bus.imem_we, bus.io_we, bus.io_re} !== 13'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_enables: got %b/%b/%b io_re %b want all 0", bus.dmem_we, bus.imem_we, bus.io_we, bus.io_re);
        end
        advance_cycle(1'b0);
        rst = 1'b0;
        drive_cpu(1'b1, 32'h1000_0000, 32'h0, 1'b0, SZ_W);
        drive_dma(1'b1, 32'h1000_0004, 32'h0, 1'b0, SZ_W);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_cmp++;
                if (bus.rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL post_reset_rsp_valid: got %b want 0", bus.rsp_valid);
                end
            end
            exp_dma = (i == 4);
            n_cmp++;
            if ({bus.cpu_ready, bus.dma_ready} !== {!exp_dma, exp_dma}) begin
                n_fail++;
                $display("[TB] FAIL post_reset_grant[%0d]: got cpu %b dma %b want cpu %b dma %b", i, bus.cpu_ready, bus.dma_ready, !exp_dma, exp_dma);
            end
            advance_cycle(1'b0);
        end
        drive_cpu(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        drive_dma(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        @(negedge clk);
        advance_cycle(1'b0);
    endtask

    initial begin
        drive_cpu(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        drive_dma(1'b0, 32'h0, 32'h0, 1'b0, SZ_W);
        bus.imem_wr_en = 1'b0;
        bus.dmem_dout  = 32'h1357_9BDF;
        bus.bios_dout  = 32'hDEAD_BEEF;
        bus.io_dout    = 32'h0000_0055;
        $display("[TB] starting mem_port_arbiter bench");
        test_reset();
        test_store_lanes();
        test_dimem();
        test_loads();
        test_misaligned();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
